// File: rtl/fifo_controller_if.sv
// Stream bundle between the packet source, the elastic FIFO and the downstream QoS stage.
// The source drives wdata/valid_in; the FIFO returns the drained word on rdata/valid_out.
interface fifo_controller_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] wdata;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  valid_out;

  modport master (
    output wdata,
    output valid_in,
    input  rdata,
    input  valid_out
  );

  modport slave (
    input  wdata,
    input  valid_in,
    output rdata,
    output valid_out
  );

endinterface

// File: rtl/fifo_controller.sv
// Elastic byte buffer: a circular FIFO that stores qualified input words and drains
// one word per cycle whenever it holds data. Words offered while full are dropped.
module fifo_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic              wclk,
  input  logic              wrst_n,
  fifo_controller_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  valid_out_reg;

  logic fifo_rempty;
  logic fifo_wfull;
  logic fifo_wen;
  logic fifo_ren;

  // The extra MSB of each pointer separates "full" from "empty" when the addresses match.
  assign fifo_rempty = (wptr == rptr);
  assign fifo_wfull  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                       (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

  assign fifo_wen = bus.valid_in & ~fifo_wfull;
  assign fifo_ren = ~fifo_rempty;

  always_ff @(posedge wclk) begin
    if (fifo_wen) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= bus.wdata;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr <= '0;
    end else if (fifo_wen) begin
      wptr <= wptr + 1'b1;
    end
  end

  // rdata keeps its last word on idle cycles; only valid_out marks a fresh one.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rptr          <= '0;
      rdata_reg     <= '0;
      valid_out_reg <= 1'b0;
    end else if (fifo_ren) begin
      rptr          <= rptr + 1'b1;
      rdata_reg     <= mem[rptr[ADDR_WIDTH-1:0]];
      valid_out_reg <= 1'b1;
    end else begin
      valid_out_reg <= 1'b0;
    end
  end

  assign bus.rdata     = rdata_reg;
  assign bus.valid_out = valid_out_reg;

endmodule

// File: tb/tb_fifo_controller.sv
// Self-checking bench for fifo_controller: directed phases with random data,
// compared every cycle against a queue-based model of the buffer.
module tb_fifo_controller;

  localparam int DEPTH = 16;

  logic wclk;
  logic wrst_n;
  int   checks;
  int   failures;
  int   pulses;
  logic [7:0] model_q [$];
  logic [7:0] exp_rdata;
  logic       exp_valid;

  fifo_controller_if #(.DATA_WIDTH(8)) bus ();

  fifo_controller #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string phase);
    compare({phase, ".valid_out"}, 32'(bus.valid_out), 32'(exp_valid));
    compare({phase, ".rdata"}, 32'(bus.rdata), 32'(exp_rdata));
    compare({phase, ".rempty"}, 32'(dut.fifo_rempty), 32'(model_q.size() == 0));
    compare({phase, ".wfull"}, 32'(dut.fifo_wfull), 32'(model_q.size() == DEPTH));
  endtask

  // One clock of stimulus; the model pops/pushes using the pre-edge occupancy.
  task automatic apply_stimulus(input logic v, input logic [7:0] d, input bit stall,
                                input string phase);
    bit full;
    bit ren;
    bus.valid_in = v;
    bus.wdata    = d;
    if (stall) force dut.fifo_ren = 1'b0;
    else       release dut.fifo_ren;
    full = (model_q.size() == DEPTH);
    ren  = !stall && (model_q.size() != 0);
    @(posedge wclk);
    #1;
    if (ren) begin
      exp_rdata = model_q.pop_front();
      exp_valid = 1'b1;
      pulses++;
    end else begin
      exp_valid = 1'b0;
    end
    if (v && !full) model_q.push_back(d);
    check_output(phase);
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic apply_reset(input string phase);
    #2;
    bus.valid_in = 1'b0;
    release dut.fifo_ren;
    wrst_n = 1'b0;
    #1;
    model_q.delete();
    exp_rdata = 8'h00;
    exp_valid = 1'b0;
    check_output({phase, ".async"});
    repeat (3) begin
      @(posedge wclk);
      #1;
      check_output({phase, ".hold"});
    end
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    pulses    = 0;
    exp_rdata = 8'h00;
    exp_valid = 1'b0;
    wrst_n    = 1'b1;
    bus.valid_in = 1'b0;
    bus.wdata    = 8'h00;
    @(posedge wclk);
    #1;

    $display("[TB] reset");
    apply_reset("reset");

    $display("[TB] single word");
    apply_stimulus(1'b1, 8'hA5, 1'b0, "single.w");
    compare("single.not_yet", 32'(bus.valid_out), 32'd0);
    apply_stimulus(1'b0, 8'h00, 1'b0, "single.r");
    compare("single.valid_const", 32'(bus.valid_out), 32'd1);
    compare("single.rdata_const", 32'(bus.rdata), 32'hA5);
    apply_stimulus(1'b0, 8'h00, 1'b0, "single.after");
    compare("single.one_pulse", 32'(bus.valid_out), 32'd0);

    $display("[TB] burst");
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(1'b1, 8'($urandom), 1'b0, "burst");
    end
    repeat (3) apply_stimulus(1'b0, 8'h00, 1'b0, "burst.drain");
    compare("burst.pulses", 32'(pulses), 32'd32);

    $display("[TB] fill and overflow");
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(1'b1, 8'(i), 1'b1, "fill");
      if (i == 15) compare("fill.full_after_16", 32'(dut.fifo_wfull), 32'd1);
    end
    pulses = 0;
    for (int i = 0; i < 18; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b0, "fill.drain");
      if (i == 15) compare("fill.last_word", 32'(bus.rdata), 32'd15);
    end
    compare("fill.pulses", 32'(pulses), 32'd16);

    $display("[TB] wrap-around");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) apply_stimulus(1'b1, 8'($urandom), 1'b1, "wrap.fill");
      for (int i = 0; i < 13; i++) apply_stimulus(1'b0, 8'h00, 1'b0, "wrap.drain");
    end
    compare("wrap.empty_end", 32'(dut.fifo_rempty), 32'd1);

    $display("[TB] random mix");
    for (int i = 0; i < 80; i++) begin
      apply_stimulus(1'($urandom_range(0, 3) != 0), 8'($urandom),
                     bit'($urandom_range(0, 2) != 0), "mix");
    end
    repeat (18) apply_stimulus(1'b0, 8'h00, 1'b0, "mix.drain");

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 8'($urandom), 1'b1, "midrst.fill");
    apply_stimulus(1'b0, 8'h00, 1'b0, "midrst.live");
    compare("midrst.live_valid", 32'(bus.valid_out), 32'd1);
    apply_reset("midrst");
    pulses = 0;
    repeat (8) apply_stimulus(1'b0, 8'h00, 1'b0, "midrst.idle");
    compare("midrst.no_stale", 32'(pulses), 32'd0);
    compare("midrst.valid_low", 32'(bus.valid_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
